instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 58 +++++
 tb/tb_instr_fetch.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC register plus IF/ID stage registers with branch redirect, stall/flush
// handling and a sticky fault state for out-of-range fetch addresses.
module instr_fetch #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        fault,
  output logic [31:0] fetch_count
);
  typedef enum logic {RUN, FAULT} state_t;
  localparam logic [63:0] LAST = 64'(MEM_BYTES) - 64'd4;
  state_t state;
  logic [63:0] pc;
  logic bad;
  // Compare against the last word address rather than adding 3, so huge targets cannot wrap.
  assign bad = (br_target[1:0] != 2'b00) || (br_target > LAST);
  assign imem_addr = pc;
  assign fault = state == FAULT;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc <= RESET_PC;
      if_pc <= '0;
      if_instr <= '0;
      if_valid <= 1'b0;
      fetch_count <= '0;
    end else if (state == FAULT) begin
      if_valid <= 1'b0;
    end else if (br_taken) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if (bad) state <= FAULT;
      else pc <= br_target;
    end else if (flush) begin
      if_valid <= 1'b0;
      if_instr <= '0;
    end else if (!stall) begin
      if_pc <= pc;
      if_instr <= imem_instr;
      if_valid <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
      // The last word is still delivered; only the PC advance past memory faults.
      if (pc == LAST) state <= FAULT;
      else pc <= pc + 64'd4;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch, stall, flush, branch, fault and reset behaviour.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] br_target = '0;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        fault;
  logic [31:0] fetch_count;
  int tests = 0;
  int fails = 0;

  instr_fetch #(.MEM_BYTES(1024), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .flush(flush), .br_taken(br_taken), .br_target(br_target),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .fault(fault),
    .fetch_count(fetch_count)
  );

  assign imem_instr = imem_addr[33:2];
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_pc", if_pc, 64'd0);
    chk("rst_instr", 64'(if_instr), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_count", 64'(fetch_count), 64'd0);
    reset = 1'b0;
    step();
    chk("seq0_pc", if_pc, 64'd0);
    chk("seq0_instr", 64'(if_instr), 64'd0);
    chk("seq0_valid", 64'(if_valid), 64'd1);
    step();
    chk("seq1_pc", if_pc, 64'd4);
    chk("seq1_instr", 64'(if_instr), 64'd1);
    stall = 1'b1;
    step();
    step();
    chk("stall_pc", if_pc, 64'd4);
    chk("stall_addr", imem_addr, 64'd8);
    chk("stall_valid", 64'(if_valid), 64'd1);
    chk("stall_count", 64'(fetch_count), 64'd2);
    stall = 1'b0;
    step();
    chk("rel_pc", if_pc, 64'd8);
    chk("rel_instr", 64'(if_instr), 64'd2);
    step();
    chk("seq3_pc", if_pc, 64'd12);
    chk("seq3_instr", 64'(if_instr), 64'd3);
    chk("seq3_count", 64'(fetch_count), 64'd4);
    chk("seq3_addr", imem_addr, 64'h10);
    br_taken = 1'b1;
    br_target = 64'h40;
    step();
    chk("br_addr", imem_addr, 64'h40);
    chk("br_valid", 64'(if_valid), 64'd0);
    chk("br_instr", 64'(if_instr), 64'd0);
    chk("br_count", 64'(fetch_count), 64'd4);
    br_taken = 1'b0;
    step();
    chk("br2_pc", if_pc, 64'h40);
    chk("br2_instr", 64'(if_instr), 64'h10);
    chk("br2_valid", 64'(if_valid), 64'd1);
    chk("br2_count", 64'(fetch_count), 64'd5);
    flush = 1'b1;
    stall = 1'b1;
    step();
    chk("fl_valid", 64'(if_valid), 64'd0);
    chk("fl_instr", 64'(if_instr), 64'd0);
    chk("fl_pc", if_pc, 64'h40);
    chk("fl_count", 64'(fetch_count), 64'd5);
    flush = 1'b0;
    br_taken = 1'b1;
    br_target = 64'h20;
    step();
    chk("stbr_addr", imem_addr, 64'h20);
    chk("stbr_valid", 64'(if_valid), 64'd0);
    br_taken = 1'b0;
    stall = 1'b0;
    step();
    chk("stbr2_pc", if_pc, 64'h20);
    chk("stbr2_instr", 64'(if_instr), 64'd8);
    chk("stbr2_count", 64'(fetch_count), 64'd6);
    br_taken = 1'b1;
    br_target = 64'h42;
    step();
    chk("bad42_fault", 64'(fault), 64'd1);
    chk("bad42_valid", 64'(if_valid), 64'd0);
    chk("bad42_addr", imem_addr, 64'h24);
    br_target = 64'h40;
    step();
    chk("fhold_fault", 64'(fault), 64'd1);
    chk("fhold_addr", imem_addr, 64'h24);
    chk("fhold_pc", if_pc, 64'h20);
    chk("fhold_count", 64'(fetch_count), 64'd6);
    br_taken = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_fault", 64'(fault), 64'd0);
    chk("async_addr", imem_addr, 64'd0);
    chk("async_count", 64'(fetch_count), 64'd0);
    chk("async_pc", if_pc, 64'd0);
    reset = 1'b0;
    step();
    chk("first_pc", if_pc, 64'd0);
    chk("first_valid", 64'(if_valid), 64'd1);
    br_taken = 1'b1;
    br_target = 64'd1024;
    step();
    chk("badmem_fault", 64'(fault), 64'd1);
    chk("badmem_valid", 64'(if_valid), 64'd0);
    chk("badmem_addr", imem_addr, 64'd4);
    do_reset();
    chk("rst2_fault", 64'(fault), 64'd0);
    chk("rst2_addr", imem_addr, 64'd0);
    br_target = 64'd1016;
    step();
    chk("end_addr", imem_addr, 64'd1016);
    br_taken = 1'b0;
    step();
    chk("end0_pc", if_pc, 64'd1016);
    chk("end0_instr", 64'(if_instr), 64'd254);
    chk("end0_fault", 64'(fault), 64'd0);
    step();
    chk("end1_pc", if_pc, 64'd1020);
    chk("end1_instr", 64'(if_instr), 64'd255);
    chk("end1_valid", 64'(if_valid), 64'd1);
    chk("end1_fault", 64'(fault), 64'd1);
    chk("end1_addr", imem_addr, 64'd1020);
    step();
    chk("end2_valid", 64'(if_valid), 64'd0);
    chk("end2_fault", 64'(fault), 64'd1);
    chk("end2_addr", imem_addr, 64'd1020);
    do_reset();
    br_taken = 1'b1;
    br_target = 64'd1020;
    step();
    br_taken = 1'b0;
    stall = 1'b1;
    step();
    step();
    chk("lstall_fault", 64'(fault), 64'd0);
    chk("lstall_addr", imem_addr, 64'd1020);
    stall = 1'b0;
    step();
    chk("lrun_fault", 64'(fault), 64'd1);
    chk("lrun_pc", if_pc, 64'd1020);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
